ball_move: RTL and testbench
============================

BALL_MOVE -- requirements
Module: ball_move

Interface
REQ-001 Parameters (name, default, meaning): X_MIN 0, left wall px; X_MAX 639, right wall px; Y_MIN 0, top wall px; Y_MAX 479, bottom wall px; X_CENTER 320, reset x px; Y_CENTER 240, reset y px; ACC_SHIFT 4, arithmetic right shift applied to sin to form acceleration; VEL_MAX 1023, velocity magnitude limit.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 tick  input  1  frame-update strobe, one cycle wide.
REQ-005 sin_x, sin_y  input  11 each  signed two's-complement slope components from the upstream sine stage.
REQ-006 pos_x, pos_y  output  10 each  ball position, integer pixels.
REQ-007 vel_x, vel_y  output  12 each  signed velocity, units 1/64 px per frame.
REQ-008 hit_x, hit_y  output  1 each  one-cycle wall-collision flags, valid with done.
REQ-009 busy  output  1  high while an update is in flight; done  output  1  one-cycle update-complete pulse.

Function
REQ-010 Internal position is 16-bit unsigned fixed point, 10.6; pos_x/pos_y are bits [15:6].
REQ-011 FSM states IDLE, ACCEL, MOVE, BOUND; IDLE->ACCEL on tick, ACCEL->MOVE, MOVE->BOUND, BOUND->IDLE unconditionally.
REQ-012 On the edge sampling tick=1 in IDLE: sin_x/sin_y latched; busy=1 from the next cycle.
REQ-013 ACCEL: vel += (sin >>> ACC_SHIFT), sign-extended, then saturated to [-VEL_MAX, +VEL_MAX].
REQ-014 MOVE: candidate = pos + sign-extended vel, computed in 17-bit signed arithmetic.
REQ-015 BOUND, per axis independently: candidate < MIN*64 (including negative) -> pos = MIN*64, hit=1; candidate > MAX*64+63 -> pos = MAX*64, hit=1; otherwise pos = candidate, hit=0.
REQ-016 On a hit, velocity is modified per REQ-026/027. The non-hit axis is unaffected.
REQ-017 Latency: edge sampling tick = E0; pos, vel, hit and done update at E3; done=1 and busy=0 for the cycle after E3.
REQ-018 tick while busy=1, or in the done cycle, is ignored with no queuing.
REQ-019 sin_x/sin_y changes after E0 do not affect the update in flight.
REQ-020 Simultaneous x and y hits both assert in the same done cycle.
REQ-021 Outputs hold their values between updates; hit_x/hit_y are 0 except in done cycles.

Reset
REQ-022 rst=0 at a rising edge forces IDLE from any state, including mid-update.
REQ-023 Reset values: pos_x=X_CENTER and pos_y=Y_CENTER (fraction 0); vel_x=vel_y=0; hit_x=hit_y=0; busy=0; done=0.
REQ-024 An update interrupted by reset is discarded; no done pulse results from it.
REQ-025 tick is ignored while rst=0.

Configuration
REQ-026 With BALL_BOUNCE_EN defined, a hit axis gets vel = -(vel >>> 1), i.e. reversed and halved.
REQ-027 Without BALL_BOUNCE_EN, a hit axis gets vel = 0, i.e. stops at the wall. All other behaviour is identical.

Verification
REQ-028 Reset released, sin_x=256, sin_y=0, 4 ticks -> vel_x 16,32,48,64; pos_x=322; pos_y=240; vel_y=0; no hits.
REQ-029 From reset, sin_x=-256, 1 tick -> vel_x=-16 (0xFF0), pos_x=319, done exactly 3 cycles after the tick-sampling edge.
REQ-030 sin_x=1023 for 17 ticks -> vel_x accumulates by 63 per tick and saturates at 1023, never exceeding it.
REQ-031 sin_x=1023 and sin_y=-1024 held until both hits -> pos_x=639 with hit_x, pos_y=0 with hit_y. With BALL_BOUNCE_EN, vel sign flips at half magnitude. Without it, vel=0 on the hit axis.
REQ-032 tick asserted 2 consecutive cycles with sin_x=256 -> exactly one done, vel_x=16. A further tick during busy -> no effect.
REQ-033 rst=0 for one edge in the MOVE state -> no done; pos=(320,240); vel=0; busy=0 on the next cycle; a subsequent tick completes normally.

Source files
------------

// File: rtl/ball_move.sv
// Ball physics: integrates slope into velocity and velocity into 10.6 position, clamping at walls.
// Three cycles from accepted tick to done; ticks while busy or in the done cycle are dropped. Optional BALL_BOUNCE_EN.
module ball_move #(
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 240,
  parameter int ACC_SHIFT = 4,
  parameter int VEL_MAX   = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic signed [10:0] sin_x,
  input  logic signed [10:0] sin_y,
  output logic        [9:0]  pos_x,
  output logic        [9:0]  pos_y,
  output logic signed [11:0] vel_x,
  output logic signed [11:0] vel_y,
  output logic               hit_x,
  output logic               hit_y,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, ACCEL, MOVE, BOUND} state_t;

  typedef struct packed {
    logic        [15:0] pos;
    logic signed [11:0] vel;
    logic               hit;
  } axis_t;

  localparam logic signed [12:0] VMAX   = 13'(VEL_MAX);
  localparam logic signed [12:0] VMIN   = 13'(-VEL_MAX);
  localparam logic signed [16:0] X_LO   = 17'(X_MIN * 64);
  localparam logic signed [16:0] X_HI   = 17'(X_MAX * 64 + 63);
  localparam logic signed [16:0] Y_LO   = 17'(Y_MIN * 64);
  localparam logic signed [16:0] Y_HI   = 17'(Y_MAX * 64 + 63);
  localparam logic        [15:0] X_LOP  = 16'(X_MIN * 64);
  localparam logic        [15:0] X_HIP  = 16'(X_MAX * 64);
  localparam logic        [15:0] Y_LOP  = 16'(Y_MIN * 64);
  localparam logic        [15:0] Y_HIP  = 16'(Y_MAX * 64);
  localparam logic        [15:0] X_RST  = 16'(X_CENTER * 64);
  localparam logic        [15:0] Y_RST  = 16'(Y_CENTER * 64);

  state_t             state_q, state_d;
  logic signed [10:0] sx_q, sy_q;
  logic        [15:0] px_q, py_q;
  logic signed [11:0] vx_q, vy_q;
  logic signed [11:0] nvx_q, nvy_q;
  logic signed [16:0] cx_q, cy_q;
  logic               hx_q, hy_q, done_q;

  logic               accept;
  logic signed [11:0] nvx_d, nvy_d;
  logic signed [16:0] cx_d, cy_d;
  axis_t              bx_d, by_d;

  function automatic logic signed [11:0] accel(input logic signed [11:0] v,
                                               input logic signed [10:0] s);
    logic signed [12:0] a;
    logic signed [12:0] sum;
    a   = $signed({{2{s[10]}}, s}) >>> ACC_SHIFT;
    sum = $signed({v[11], v}) + a;
    if (sum > VMAX)      return VMAX[11:0];
    else if (sum < VMIN) return VMIN[11:0];
    else                 return sum[11:0];
  endfunction

  function automatic axis_t bound(input logic signed [16:0] c,
                                  input logic signed [16:0] lo,
                                  input logic signed [16:0] hi,
                                  input logic        [15:0] lo_pos,
                                  input logic        [15:0] hi_pos,
                                  input logic signed [11:0] v);
    axis_t r;
    logic signed [11:0] vhit;
`ifdef BALL_BOUNCE_EN
    vhit = -(v >>> 1);
`else
    vhit = '0;
`endif
    r.pos = c[15:0];
    r.vel = v;
    r.hit = 1'b0;
    if (c < lo) begin
      r.pos = lo_pos;
      r.vel = vhit;
      r.hit = 1'b1;
    end else if (c > hi) begin
      r.pos = hi_pos;
      r.vel = vhit;
      r.hit = 1'b1;
    end
    return r;
  endfunction

  // The done cycle still sits in IDLE, so it must be excluded explicitly.
  assign accept = (state_q == IDLE) && tick && !done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCEL;
      ACCEL:   state_d = MOVE;
      MOVE:    state_d = BOUND;
      BOUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nvx_d = accel(vx_q, sx_q);
    nvy_d = accel(vy_q, sy_q);
    cx_d  = $signed({1'b0, px_q}) + $signed({{5{nvx_q[11]}}, nvx_q});
    cy_d  = $signed({1'b0, py_q}) + $signed({{5{nvy_q[11]}}, nvy_q});
    bx_d  = bound(cx_q, X_LO, X_HI, X_LOP, X_HIP, nvx_q);
    by_d  = bound(cy_q, Y_LO, Y_HI, Y_LOP, Y_HIP, nvy_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sx_q   <= '0;
      sy_q   <= '0;
      px_q   <= X_RST;
      py_q   <= Y_RST;
      vx_q   <= '0;
      vy_q   <= '0;
      nvx_q  <= '0;
      nvy_q  <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
      hx_q   <= 1'b0;
      hy_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      hx_q   <= 1'b0;
      hy_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          sx_q <= sin_x;
          sy_q <= sin_y;
        end
        ACCEL: begin
          nvx_q <= nvx_d;
          nvy_q <= nvy_d;
        end
        MOVE: begin
          cx_q <= cx_d;
          cy_q <= cy_d;
        end
        BOUND: begin
          px_q   <= bx_d.pos;
          py_q   <= by_d.pos;
          vx_q   <= bx_d.vel;
          vy_q   <= by_d.vel;
          hx_q   <= bx_d.hit;
          hy_q   <= by_d.hit;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pos_x = px_q[15:6];
  assign pos_y = py_q[15:6];
  assign vel_x = vx_q;
  assign vel_y = vy_q;
  assign hit_x = hx_q;
  assign hit_y = hy_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_ball_move.sv
// Self-checking bench for ball_move: vector table, per-update scoreboard, and reset/tick corner sequences.
module tb_ball_move;

  logic               clk = 1'b0;
  logic               rst;
  logic               tick;
  logic signed [10:0] sin_x, sin_y;
  logic        [9:0]  pos_x, pos_y;
  logic signed [11:0] vel_x, vel_y;
  logic               hit_x, hit_y, busy, done;

  always #5 clk = ~clk;

  ball_move dut (
    .clk(clk), .rst(rst), .tick(tick), .sin_x(sin_x), .sin_y(sin_y),
    .pos_x(pos_x), .pos_y(pos_y), .vel_x(vel_x), .vel_y(vel_y),
    .hit_x(hit_x), .hit_y(hit_y), .busy(busy), .done(done)
  );

  typedef struct {int px; int py; int vx; int vy; int hx; int hy;} exp_t;
  typedef struct {int sx; int sy; int n; int px; int py; int vx; int vy;} vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_px, m_py, m_vx, m_vy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_px = 320 * 64;
    m_py = 240 * 64;
    m_vx = 0;
    m_vy = 0;
  endtask

  task automatic model_axis(input int s, input int lo, input int hi,
                            inout int p, inout int v, output int h);
    int c;
    v = v + (s >>> 4);
    if (v > 1023)  v = 1023;
    if (v < -1023) v = -1023;
    c = p + v;
    h = 0;
    if (c < lo * 64 || c > hi * 64 + 63) begin
      p = (c < lo * 64) ? lo * 64 : hi * 64;
      h = 1;
`ifdef BALL_BOUNCE_EN
      v = -(v >>> 1);
`else
      v = 0;
`endif
    end else begin
      p = c;
    end
  endtask

  task automatic model_step(input int sx, input int sy);
    exp_t e;
    int hx, hy;
    model_axis(sx, 0, 639, m_px, m_vx, hx);
    model_axis(sy, 0, 479, m_py, m_vy, hy);
    e.px = m_px / 64; e.py = m_py / 64;
    e.vx = m_vx;      e.vy = m_vy;
    e.hx = hx;        e.hy = hy;
    exp_q.push_back(e);
  endtask

  task automatic compare_done(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, "_pos_x"}, int'(pos_x), e.px);
    chk({tag, "_pos_y"}, int'(pos_y), e.py);
    chk({tag, "_vel_x"}, int'(vel_x), e.vx);
    chk({tag, "_vel_y"}, int'(vel_y), e.vy);
    chk({tag, "_hit_x"}, int'(hit_x), e.hx);
    chk({tag, "_hit_y"}, int'(hit_y), e.hy);
    chk({tag, "_busy"},  int'(busy),  0);
  endtask

  task automatic do_reset();
    tick = 1'b0;
    rst  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  // Returns in the done cycle, #1 after the completing edge.
  task automatic run_update(input int sx, input int sy, input bit scramble);
    int c;
    @(posedge clk); #1;
    sin_x = 11'(sx);
    sin_y = 11'(sy);
    tick  = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    chk("busy_after_tick", int'(busy), 1);
    model_step(sx, sy);
    if (scramble) begin
      sin_x = 11'($urandom);
      sin_y = 11'($urandom);
    end
    c = 0;
    while (!done && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    chk("done_latency", c, 3);
    compare_done("upd");
  endtask

  vec_t vecs[4];
  int   dones;
  bit   seen_x, seen_y;
  int   n;

  initial begin
    vecs[0] = '{256,     0,  4, 322, 240,   64,   0};
    vecs[1] = '{-256,    0,  1, 319, 240,  -16,   0};
    vecs[2] = '{1023,    0, 17, 469, 240, 1023,   0};
    vecs[3] = '{0,    -256,  3, 320, 238,    0, -48};

    // Reset state, with tick held high during reset.
    rst = 1'b0; tick = 1'b1; sin_x = 11'sd256; sin_y = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; tick = 1'b0;
    model_reset();
    chk("rst_pos_x", int'(pos_x), 320);
    chk("rst_pos_y", int'(pos_y), 240);
    chk("rst_vel_x", int'(vel_x), 0);
    chk("rst_vel_y", int'(vel_y), 0);
    chk("rst_hit",   int'(hit_x | hit_y), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    dones = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("tick_in_reset_ignored", dones, 0);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      for (int k = 0; k < vecs[i].n; k++) run_update(vecs[i].sx, vecs[i].sy, k[0]);
      chk($sformatf("vec%0d_pos_x", i), int'(pos_x), vecs[i].px);
      chk($sformatf("vec%0d_pos_y", i), int'(pos_y), vecs[i].py);
      chk($sformatf("vec%0d_vel_x", i), int'(vel_x), vecs[i].vx);
      chk($sformatf("vec%0d_vel_y", i), int'(vel_y), vecs[i].vy);
    end

    // Drive into both walls.
    do_reset();
    seen_x = 1'b0; seen_y = 1'b0; n = 0;
    while (!seen_x && n < 80) begin
      run_update(1023, -1024, 1'b0);
      n++;
      if (hit_y && !seen_y) begin
        seen_y = 1'b1;
        chk("wall_pos_y", int'(pos_y), 0);
`ifdef BALL_BOUNCE_EN
        chk("wall_vel_y", int'(vel_y), 512);
`else
        chk("wall_vel_y", int'(vel_y), 0);
`endif
      end
      if (hit_x) begin
        seen_x = 1'b1;
        chk("wall_pos_x", int'(pos_x), 639);
`ifdef BALL_BOUNCE_EN
        chk("wall_vel_x", int'(vel_x), -511);
`else
        chk("wall_vel_x", int'(vel_x), 0);
`endif
      end
    end
    chk("wall_both_hits_seen", int'(seen_x && seen_y), 1);
    @(posedge clk); #1;
    chk("hit_cleared_after_done", int'(hit_x | hit_y), 0);

    // Two-cycle tick, then ticks during busy and during the done cycle.
    do_reset();
    @(posedge clk); #1;
    sin_x = 11'sd256; sin_y = '0; tick = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    tick = 1'b0;
    model_step(256, 0);
    dones = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      tick = 1'b0;
      if (done) begin
        dones++;
        if (dones == 1) compare_done("dbl");
        tick = 1'b1;
      end
      if (cyc == 0) tick = 1'b1;
    end
    tick = 1'b0;
    chk("dbl_done_count", dones, 1);
    chk("dbl_vel_x_final", int'(vel_x), 16);

    // Reset pulse while in MOVE.
    do_reset();
    @(posedge clk); #1;
    sin_x = 11'sd256; sin_y = '0; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_busy",  int'(busy), 0);
    chk("midrst_pos_x", int'(pos_x), 320);
    chk("midrst_pos_y", int'(pos_y), 240);
    chk("midrst_vel_x", int'(vel_x), 0);
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("midrst_no_done", dones, 0);
    model_reset();
    exp_q.delete();
    run_update(256, 0, 1'b1);
    chk("midrst_after_vel_x", int'(vel_x), 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
